// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC scanner and the text overlay that reads its bank.
// Latency: n/a (constants, types and one address-map helper only).
// Backpressure: n/a.
// Contents: display position indices, RTC register addresses, FSM state
// encoding and the packed bundle of registered bus-pin drives.
package rtc_pkg;

   localparam int NUM_IDX = 9;

   // Display position indices, shared with the character generator.
   localparam logic [3:0] IDX_SEG  = 4'd0;
   localparam logic [3:0] IDX_MIN  = 4'd1;
   localparam logic [3:0] IDX_HOR  = 4'd2;
   localparam logic [3:0] IDX_DAY  = 4'd3;
   localparam logic [3:0] IDX_MON  = 4'd4;
   localparam logic [3:0] IDX_YEAR = 4'd5;
   localparam logic [3:0] IDX_TSEG = 4'd6;
   localparam logic [3:0] IDX_TMIN = 4'd7;
   localparam logic [3:0] IDX_THOR = 4'd8;
   localparam logic [3:0] IDX_NONE = 4'd9;

   // RTC chip register addresses.
   localparam logic [7:0] RTC_SEG  = 8'h21;
   localparam logic [7:0] RTC_MIN  = 8'h22;
   localparam logic [7:0] RTC_HOR  = 8'h23;
   localparam logic [7:0] RTC_DAY  = 8'h24;
   localparam logic [7:0] RTC_MON  = 8'h25;
   localparam logic [7:0] RTC_YEAR = 8'h26;
   localparam logic [7:0] RTC_TSEG = 8'h41;
   localparam logic [7:0] RTC_TMIN = 8'h42;
   localparam logic [7:0] RTC_THOR = 8'h43;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_AHOLD,
      ST_READ,
      ST_RECOV,
      ST_DONE
   } rtc_state_t;

   // Everything driven onto the RTC pins, registered as one bundle.
   typedef struct packed {
      logic       cs_n;
      logic       rd_n;
      logic       wr_n;
      logic       ad_oe;
      logic       a_d;
      logic [7:0] ad;
   } bus_drv_t;

   localparam bus_drv_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                     ad_oe: 1'b0, a_d: 1'b0, ad: 8'h00};

   function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
      case (idx)
         IDX_SEG:  return RTC_SEG;
         IDX_MIN:  return RTC_MIN;
         IDX_HOR:  return RTC_HOR;
         IDX_DAY:  return RTC_DAY;
         IDX_MON:  return RTC_MON;
         IDX_YEAR: return RTC_YEAR;
         IDX_TSEG: return RTC_TSEG;
         IDX_TMIN: return RTC_TMIN;
         IDX_THOR: return RTC_THOR;
         default:  return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/rtc_reg_bank.sv
// 9x8 register file holding the scanned BCD bytes for the display.
// Latency: write lands on the clock edge; read is combinational (old byte during its write cycle).
// Backpressure: none; writes always accepted, out-of-range indices ignored / read as 0.
// Ports: clk, reset (async high), wr_en/wr_addr/wr_data write port,
//        rd_addr in / rd_data out combinational read port.
module rtc_reg_bank
   import rtc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [NUM_IDX];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_IDX; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (wr_en && (wr_addr < IDX_NONE)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = (rd_addr < IDX_NONE) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/rtc_bus_reader.sv
// Scans the nine RTC time/date/timer registers over the muxed A/D bus into a local bank.
// Latency: refresh_req at t -> ADDR at t+2; 4*PHASE_CYCLES clocks per register, +1 DONE cycle.
// Backpressure: requests during a scan collapse into a single pending follow-up scan.
// Ports: clk, reset (async high), refresh_req; rd_addr/rd_data display read port;
//        rtc_ad_out/rtc_ad_in/rtc_ad_oe/rtc_a_d/rtc_cs_n/rtc_rd_n/rtc_wr_n RTC pins;
//        busy, scan_done status.
module rtc_bus_reader
   import rtc_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int AUTO_PERIOD  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refresh_req,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [7:0] rtc_ad_out,
   input  logic [7:0] rtc_ad_in,
   output logic       rtc_ad_oe,
   output logic       rtc_a_d,
   output logic       rtc_cs_n,
   output logic       rtc_rd_n,
   output logic       rtc_wr_n,
   output logic       busy,
   output logic       scan_done
);

   localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);
   localparam logic [AW-1:0] AUTO_LAST  = AW'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);

   rtc_state_t    state, state_nxt;
   logic [PW-1:0] phase, phase_nxt;
   logic [3:0]    idx, idx_nxt;
   logic          pending, pending_nxt;
   logic [AW-1:0] auto_cnt;
   logic          auto_hit;
   logic          phase_last;
   logic          bank_we;
   bus_drv_t      bus_q, bus_nxt;

   // Free-running auto-refresh counter; independent of scan activity.
   assign auto_hit = (AUTO_PERIOD > 0) && (auto_cnt == AUTO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         auto_cnt <= '0;
      end else if ((AUTO_PERIOD == 0) || auto_hit) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + 1'b1;
      end
   end

   assign phase_last = (phase == PHASE_LAST);

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      phase_nxt   = '0;
      bank_we     = 1'b0;
      // A new request in the same cycle IDLE consumes pending keeps it set,
      // which yields exactly one follow-up scan.
      pending_nxt = pending | refresh_req | auto_hit;
      case (state)
         ST_IDLE: begin
            if (pending) begin
               state_nxt   = ST_ADDR;
               idx_nxt     = IDX_SEG;
               pending_nxt = refresh_req | auto_hit;
            end
         end
         ST_ADDR: begin
            phase_nxt = phase_last ? '0 : phase + 1'b1;
            if (phase_last) state_nxt = ST_AHOLD;
         end
         ST_AHOLD: begin
            phase_nxt = phase_last ? '0 : phase + 1'b1;
            if (phase_last) state_nxt = ST_READ;
         end
         ST_READ: begin
            phase_nxt = phase_last ? '0 : phase + 1'b1;
            if (phase_last) begin
               bank_we   = 1'b1;
               state_nxt = ST_RECOV;
            end
         end
         ST_RECOV: begin
            phase_nxt = phase_last ? '0 : phase + 1'b1;
            if (phase_last) begin
               if (idx < IDX_THOR) begin
                  idx_nxt   = idx + 4'd1;
                  state_nxt = ST_ADDR;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase

      // Pin drives are decoded from the next state so they come straight out
      // of flops and line up with the state they belong to.
      bus_nxt = BUS_IDLE;
      case (state_nxt)
         ST_ADDR: begin
            bus_nxt.cs_n  = 1'b0;
            bus_nxt.wr_n  = 1'b0;
            bus_nxt.ad_oe = 1'b1;
            bus_nxt.ad    = rtc_addr(idx_nxt);
         end
         ST_AHOLD: begin
            bus_nxt.cs_n  = 1'b0;
            bus_nxt.ad_oe = 1'b1;
            bus_nxt.ad    = rtc_addr(idx_nxt);
         end
         ST_READ: begin
            bus_nxt.cs_n = 1'b0;
            bus_nxt.rd_n = 1'b0;
            bus_nxt.a_d  = 1'b1;
            bus_nxt.ad   = rtc_addr(idx_nxt);
         end
         ST_RECOV: begin
            bus_nxt.a_d = 1'b1;
            bus_nxt.ad  = rtc_addr(idx_nxt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         idx       <= IDX_SEG;
         pending   <= 1'b0;
         bus_q     <= BUS_IDLE;
         busy      <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         phase     <= phase_nxt;
         idx       <= idx_nxt;
         pending   <= pending_nxt;
         bus_q     <= bus_nxt;
         busy      <= (state_nxt != ST_IDLE);
         scan_done <= (state_nxt == ST_DONE);
      end
   end

   assign rtc_cs_n   = bus_q.cs_n;
   assign rtc_rd_n   = bus_q.rd_n;
   assign rtc_wr_n   = bus_q.wr_n;
   assign rtc_ad_oe  = bus_q.ad_oe;
   assign rtc_a_d    = bus_q.a_d;
   assign rtc_ad_out = bus_q.ad;

   rtc_reg_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_we),
      .wr_addr (idx),
      .wr_data (rtc_ad_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Directed bench for rtc_bus_reader: three instances (default, PHASE_CYCLES=1,
// AUTO_PERIOD=200), each with a small RTC bus model answering a fixed byte per address.
module tb_rtc_bus_reader;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rtc_model(input logic [7:0] a);
      case (a)
         8'h21: return 8'h45;
         8'h22: return 8'h30;
         8'h23: return 8'h12;
         8'h24: return 8'h07;
         8'h25: return 8'h09;
         8'h26: return 8'h24;
         8'h41: return 8'h00;
         8'h42: return 8'h05;
         8'h43: return 8'h01;
         default: return 8'hEE;
      endcase
   endfunction

   logic [7:0] exp_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   logic [7:0] exp_data [9] = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h24, 8'h00, 8'h05, 8'h01};

   // Instance A: default parameters
   logic       refresh_a, oe_a, a_d_a, cs_n_a, rd_n_a, wr_n_a, busy_a, done_a;
   logic [3:0] rd_addr_a;
   logic [7:0] rd_data_a, ad_out_a, ad_in_a, lat_a;
   // Instance B: PHASE_CYCLES=1
   logic       refresh_b, oe_b, a_d_b, cs_n_b, rd_n_b, wr_n_b, busy_b, done_b;
   logic [3:0] rd_addr_b;
   logic [7:0] rd_data_b, ad_out_b, ad_in_b, lat_b;
   // Instance C: AUTO_PERIOD=200
   logic       refresh_c, oe_c, a_d_c, cs_n_c, rd_n_c, wr_n_c, busy_c, done_c;
   logic [3:0] rd_addr_c;
   logic [7:0] rd_data_c, ad_out_c, ad_in_c, lat_c;

   // RTC models: latch the address during the write strobe, drive data only while RD is low.
   always @(posedge clk) if (!cs_n_a && !wr_n_a) lat_a <= ad_out_a;
   always @(posedge clk) if (!cs_n_b && !wr_n_b) lat_b <= ad_out_b;
   always @(posedge clk) if (!cs_n_c && !wr_n_c) lat_c <= ad_out_c;
   assign ad_in_a = rd_n_a ? 8'hFF : rtc_model(lat_a);
   assign ad_in_b = rd_n_b ? 8'hFF : rtc_model(lat_b);
   assign ad_in_c = rd_n_c ? 8'hFF : rtc_model(lat_c);

   rtc_bus_reader dut_a (
      .clk(clk), .reset(reset), .refresh_req(refresh_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .rtc_ad_out(ad_out_a), .rtc_ad_in(ad_in_a), .rtc_ad_oe(oe_a), .rtc_a_d(a_d_a),
      .rtc_cs_n(cs_n_a), .rtc_rd_n(rd_n_a), .rtc_wr_n(wr_n_a), .busy(busy_a), .scan_done(done_a));

   rtc_bus_reader #(.PHASE_CYCLES(1), .AUTO_PERIOD(0)) dut_b (
      .clk(clk), .reset(reset), .refresh_req(refresh_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .rtc_ad_out(ad_out_b), .rtc_ad_in(ad_in_b), .rtc_ad_oe(oe_b), .rtc_a_d(a_d_b),
      .rtc_cs_n(cs_n_b), .rtc_rd_n(rd_n_b), .rtc_wr_n(wr_n_b), .busy(busy_b), .scan_done(done_b));

   rtc_bus_reader #(.PHASE_CYCLES(4), .AUTO_PERIOD(200)) dut_c (
      .clk(clk), .reset(reset), .refresh_req(refresh_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
      .rtc_ad_out(ad_out_c), .rtc_ad_in(ad_in_c), .rtc_ad_oe(oe_c), .rtc_a_d(a_d_c),
      .rtc_cs_n(cs_n_c), .rtc_rd_n(rd_n_c), .rtc_wr_n(wr_n_c), .busy(busy_c), .scan_done(done_c));

   // Runs n cycles on instance A, pulsing refresh_req at the listed offsets (-1 = unused),
   // and counts scan starts (busy rising) and scan_done pulses.
   task automatic run_window(input int n, input int p0, input int p1, input int p2, input int p3,
                             output int rises, output int dones);
      logic prev;
      prev  = busy_a;
      rises = 0;
      dones = 0;
      for (int k = 0; k < n; k++) begin
         refresh_a = (k == p0) || (k == p1) || (k == p2) || (k == p3);
         tick();
         if (busy_a && !prev) rises++;
         if (done_a) dones++;
         prev = busy_a;
      end
      refresh_a = 1'b0;
   endtask

   initial begin
      int          len, rises, dones, first_rise, second_rise, wr_lo, wr_falls, rd_lo;
      int          rd_falls, oe_bad, period_bad, last_fall, falls, waited;
      logic        prev_wr, prev_rd, prev_busy, seen;
      logic [7:0]  addr_q [$];
      logic [7:0]  first_addr_c;

      reset     = 1'b1;
      refresh_a = 1'b0;  refresh_b = 1'b0;  refresh_c = 1'b0;
      rd_addr_a = 4'd0;  rd_addr_b = 4'd9;  rd_addr_c = 4'd9;
      repeat (3) @(posedge clk);
      #1;

      // ---- reset values ----
      chk("rst_cs_n", cs_n_a, 1);
      chk("rst_rd_n", rd_n_a, 1);
      chk("rst_wr_n", wr_n_a, 1);
      chk("rst_oe", oe_a, 0);
      chk("rst_a_d", a_d_a, 0);
      chk("rst_ad_out", ad_out_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      for (int i = 0; i < 10; i++) begin
         rd_addr_a = 4'(i);
         #1;
         chk("rst_bank", rd_data_a, 0);
      end

      // ---- auto refresh on C: counter value k after the k-th edge out of reset ----
      @(negedge clk);
      reset       = 1'b0;
      first_rise  = -1;
      second_rise = -1;
      first_addr_c = 8'h00;
      prev_busy   = 1'b0;
      for (int k = 1; k <= 450; k++) begin
         tick();
         if (busy_c && !prev_busy) begin
            if (first_rise < 0) begin
               first_rise   = k;
               first_addr_c = ad_out_c;
            end else if (second_rise < 0) begin
               second_rise = k;
            end
         end
         prev_busy = busy_c;
      end
      chk("auto_first_start", first_rise, 201);
      chk("auto_second_start", second_rise, 401);
      chk("auto_first_addr", first_addr_c, 8'h21);

      // ---- single scan, default phases, on A ----
      refresh_a = 1'b1;
      tick();
      refresh_a = 1'b0;
      chk("req_t1_busy", busy_a, 0);
      tick();
      chk("addr_entry_busy", busy_a, 1);
      chk("addr_entry_cs_n", cs_n_a, 0);
      chk("addr_entry_wr_n", wr_n_a, 0);
      chk("addr_entry_oe", oe_a, 1);
      chk("addr_entry_a_d", a_d_a, 0);
      addr_q.delete();
      addr_q.push_back(ad_out_a);
      len     = 1;
      prev_wr = wr_n_a;
      seen    = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (busy_a) len++;
         if (!wr_n_a && prev_wr) addr_q.push_back(ad_out_a);
         prev_wr = wr_n_a;
         if (done_a) begin
            seen = 1'b1;
            break;
         end
      end
      chk("scan_done_seen", seen, 1);
      chk("scan_len", len, 145);
      chk("addr_count", addr_q.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (i < addr_q.size()) chk("addr_seq", addr_q[i], exp_addr[i]);
      end
      tick();
      chk("post_done_busy", busy_a, 0);
      chk("post_done_pulse", done_a, 0);
      for (int i = 0; i < 9; i++) begin
         rd_addr_a = 4'(i);
         #1;
         chk("bank_data", rd_data_a, exp_data[i]);
      end
      rd_addr_a = 4'd9;
      #1;
      chk("bank_idx9", rd_data_a, 0);
      rd_addr_a = 4'd15;
      #1;
      chk("bank_idx15", rd_data_a, 0);

      // ---- strobe timing with PHASE_CYCLES=1 on B ----
      tick();
      refresh_b = 1'b1;
      tick();
      refresh_b = 1'b0;
      tick();
      chk("p1_start", busy_b, 1);
      len = 0; wr_lo = 0; wr_falls = 0; rd_lo = 0; rd_falls = 0;
      oe_bad = 0; period_bad = 0; last_fall = -1;
      prev_wr = 1'b1; prev_rd = 1'b1; seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (busy_b) len++;
         if (!wr_n_b) wr_lo++;
         if (!rd_n_b) rd_lo++;
         if (!rd_n_b && oe_b) oe_bad++;
         if (!wr_n_b && prev_wr) begin
            wr_falls++;
            if (last_fall >= 0 && (k - last_fall) != 4) period_bad++;
            last_fall = k;
         end
         if (!rd_n_b && prev_rd) rd_falls++;
         prev_wr = wr_n_b;
         prev_rd = rd_n_b;
         if (done_b) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk("p1_done_seen", seen, 1);
      chk("p1_scan_len", len, 37);
      chk("p1_wr_low_cycles", wr_lo, 9);
      chk("p1_wr_falls", wr_falls, 9);
      chk("p1_rd_low_cycles", rd_lo, 9);
      chk("p1_rd_falls", rd_falls, 9);
      chk("p1_oe_during_rd", oe_bad, 0);
      chk("p1_txn_period", period_bad, 0);
      tick();
      rd_addr_b = 4'd0;
      #1;
      chk("p1_bank0", rd_data_b, 8'h45);
      rd_addr_b = 4'd8;
      #1;
      chk("p1_bank8", rd_data_b, 8'h01);

      // ---- overlapping requests on A ----
      run_window(400, 0, 10, 50, 100, rises, dones);
      chk("overlap_scans", rises, 2);
      chk("overlap_dones", dones, 2);
      run_window(400, 0, 1, -1, -1, rises, dones);
      chk("b2b_scans", rises, 2);
      chk("b2b_dones", dones, 2);

      // ---- reset during READ of index 4 ----
      rd_addr_a = 4'd0;
      #1;
      chk("pre_rst_bank0", rd_data_a, 8'h45);
      refresh_a = 1'b1;
      tick();
      refresh_a = 1'b0;
      falls   = 0;
      prev_rd = 1'b1;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (!rd_n_a && prev_rd) falls++;
         prev_rd = rd_n_a;
         if (falls == 5) break;
      end
      chk("midrd_reached", falls, 5);
      reset = 1'b1;
      #1;
      chk("midrd_cs_n", cs_n_a, 1);
      chk("midrd_rd_n", rd_n_a, 1);
      chk("midrd_wr_n", wr_n_a, 1);
      chk("midrd_oe", oe_a, 0);
      chk("midrd_a_d", a_d_a, 0);
      chk("midrd_ad_out", ad_out_a, 0);
      chk("midrd_busy", busy_a, 0);
      chk("midrd_bank0", rd_data_a, 0);
      @(negedge clk);
      reset = 1'b0;
      run_window(60, -1, -1, -1, -1, rises, dones);
      chk("midrd_no_restart", rises, 0);
      chk("midrd_no_done", dones, 0);
      refresh_a = 1'b1;
      tick();
      refresh_a = 1'b0;
      tick();
      chk("restart_busy", busy_a, 1);
      chk("restart_addr", ad_out_a, 8'h21);
      seen   = 1'b0;
      waited = 0;
      while (!seen && waited < 200) begin
         tick();
         waited++;
         if (done_a) seen = 1'b1;
      end
      chk("restart_done_seen", seen, 1);
      rd_addr_a = 4'd4;
      #1;
      chk("restart_bank4", rd_data_a, 8'h09);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
